// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read, dual-write register file with power-up clear sweep
// Reads are combinational with write-to-read forwarding; x0 is hardwired to zero.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    output logic                ready,
    input  logic [NRD*AW-1:0]   rd_address,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic [1:0]          wr_en,
    input  logic [2*AW-1:0]     wr_address,
    input  logic [2*XLEN-1:0]   wr_data
);

    typedef enum logic {CLEAR, RUN} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              ready_q;
    logic [XLEN-1:0]   mem_q [NREGS];

    logic [AW-1:0]     wa0, wa1;
    logic [XLEN-1:0]   wd0, wd1;
    logic              we0, we1;

    assign wa0 = wr_address[0 +: AW];
    assign wa1 = wr_address[AW +: AW];
    assign wd0 = wr_data[0 +: XLEN];
    assign wd1 = wr_data[XLEN +: XLEN];
    assign we0 = wr_en[0] && (wa0 != '0);
    assign we1 = wr_en[1] && (wa1 != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(NREGS - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // ready lags the CLEAR->RUN transition by one edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_q == RUN);
        end
    end

    // Port 1 is written last so it wins a same-address collision
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
        end else if (state_q == CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else begin
            if (we0) begin
                mem_q[wa0] <= wd0;
            end
            if (we1) begin
                mem_q[wa1] <= wd1;
            end
        end
    end

    assign ready = ready_q;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rval;

        assign ra = rd_address[i*AW +: AW];

        always_comb begin
            rval = '0;
            if (ready_q && (ra != '0)) begin
                if (wr_en[1] && (wa1 == ra)) begin
                    rval = wd1;
                end else if (wr_en[0] && (wa0 == ra)) begin
                    rval = wd0;
                end else begin
                    rval = mem_q[ra];
                end
            end
        end

        assign rd_data[i*XLEN +: XLEN] = rval;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (default and 16x64x3 configs)
module tb_regfile_mp;

    logic         clk = 1'b0;
    logic         reset;

    logic         a_ready;
    logic [9:0]   a_rd_addr;
    logic [63:0]  a_rd_data;
    logic [1:0]   a_wr_en;
    logic [9:0]   a_wr_addr;
    logic [63:0]  a_wr_data;

    logic         b_ready;
    logic [11:0]  b_rd_addr;
    logic [191:0] b_rd_data;
    logic [1:0]   b_wr_en;
    logic [7:0]   b_wr_addr;
    logic [127:0] b_wr_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    regfile_mp u_a (
        .clk        (clk),
        .reset      (reset),
        .ready      (a_ready),
        .rd_address (a_rd_addr),
        .rd_data    (a_rd_data),
        .wr_en      (a_wr_en),
        .wr_address (a_wr_addr),
        .wr_data    (a_wr_data)
    );

    regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3)) u_b (
        .clk        (clk),
        .reset      (reset),
        .ready      (b_ready),
        .rd_address (b_rd_addr),
        .rd_data    (b_rd_data),
        .wr_en      (b_wr_en),
        .wr_address (b_wr_addr),
        .wr_data    (b_wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s got %h want %h", nm, got, want);
    endtask

    // Reference model: edges seen since reset released, plus architectural contents
    int          sa = 0, sb = 0;
    logic [31:0] ma [32];
    logic [63:0] mb [16];

    always @(posedge clk) begin
        if (reset) begin
            sa = 0;
            sb = 0;
        end else begin
            if (sa >= 32) begin
                if (a_wr_en[0] && a_wr_addr[4:0] != 0) ma[a_wr_addr[4:0]] = a_wr_data[31:0];
                if (a_wr_en[1] && a_wr_addr[9:5] != 0) ma[a_wr_addr[9:5]] = a_wr_data[63:32];
            end
            if (sb >= 16) begin
                if (b_wr_en[0] && b_wr_addr[3:0] != 0) mb[b_wr_addr[3:0]] = b_wr_data[63:0];
                if (b_wr_en[1] && b_wr_addr[7:4] != 0) mb[b_wr_addr[7:4]] = b_wr_data[127:64];
            end
            if (sa < 1000) sa++;
            if (sb < 1000) sb++;
            if (sa == 32) for (int k = 0; k < 32; k++) ma[k] = '0;
            if (sb == 16) for (int k = 0; k < 16; k++) mb[k] = '0;
        end
    end

    function automatic logic [31:0] exp_a(input logic [4:0] ra);
        if (sa < 33 || ra == 0) return '0;
        if (a_wr_en[1] && a_wr_addr[9:5] == ra) return a_wr_data[63:32];
        if (a_wr_en[0] && a_wr_addr[4:0] == ra) return a_wr_data[31:0];
        return ma[ra];
    endfunction

    function automatic logic [63:0] exp_b(input logic [3:0] ra);
        if (sb < 17 || ra == 0) return '0;
        if (b_wr_en[1] && b_wr_addr[7:4] == ra) return b_wr_data[127:64];
        if (b_wr_en[0] && b_wr_addr[3:0] == ra) return b_wr_data[63:0];
        return mb[ra];
    endfunction

    always @(posedge clk) begin
        #1;
        chk("a_ready", {63'd0, a_ready}, {63'd0, sa >= 33});
        chk("b_ready", {63'd0, b_ready}, {63'd0, sb >= 17});
        for (int i = 0; i < 2; i++)
            chk($sformatf("a_rd%0d", i), {32'd0, a_rd_data[i*32 +: 32]}, {32'd0, exp_a(a_rd_addr[i*5 +: 5])});
        for (int i = 0; i < 3; i++)
            chk($sformatf("b_rd%0d", i), b_rd_data[i*64 +: 64], exp_b(b_rd_addr[i*4 +: 4]));
    end

    task automatic idle_a();
        a_wr_en = 2'b00;
        a_wr_addr = '0;
        a_wr_data = '0;
    endtask

    task automatic count_low(input string nm);
        int n;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (a_ready) break;
        end
        chk(nm, 64'(n - 1), 64'd32);
    endtask

    initial begin
        reset = 1'b1;
        idle_a();
        a_rd_addr = {5'd31, 5'd5};
        b_rd_addr = '0;
        b_wr_en = 2'b00;
        b_wr_addr = '0;
        b_wr_data = '0;

        @(posedge clk);
        #1;
        chk("reset_ready", {63'd0, a_ready}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        count_low("sweep_low_cycles");

        @(negedge clk);
        a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd5}; a_wr_data = {32'd0, 32'hDEADBEEF};
        a_rd_addr = {5'd0, 5'd5};
        #1 chk("x5_fwd", {32'd0, a_rd_data[31:0]}, 64'hDEADBEEF);
        @(negedge clk);
        idle_a();
        #1 chk("x5_stored", {32'd0, a_rd_data[31:0]}, 64'hDEADBEEF);

        @(negedge clk);
        a_wr_en = 2'b11; a_wr_addr = {5'd7, 5'd7}; a_wr_data = {32'h22, 32'h11};
        a_rd_addr = {5'd7, 5'd7};
        #1 chk("x7_fwd_p0", {32'd0, a_rd_data[31:0]}, 64'h22);
        chk("x7_fwd_p1", {32'd0, a_rd_data[63:32]}, 64'h22);
        @(negedge clk);
        idle_a();
        #1 chk("x7_stored", {32'd0, a_rd_data[31:0]}, 64'h22);

        @(negedge clk);
        a_wr_en = 2'b11; a_wr_addr = '0; a_wr_data = {32'hFFFFFFFF, 32'hFFFFFFFF};
        a_rd_addr = {5'd0, 5'd0};
        #1 chk("x0_fwd", {32'd0, a_rd_data[31:0]}, 64'd0);
        @(negedge clk);
        idle_a();
        #1 chk("x0_stored", a_rd_data, 64'd0);

        @(negedge clk);
        b_wr_en = 2'b10; b_wr_addr = {4'd3, 4'd9};
        b_wr_data = {64'h0123456789ABCDEF, 64'h5555AAAA5555AAAA};
        b_rd_addr = {4'd3, 4'd3, 4'd3};
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("b_x3_fwd%0d", i), b_rd_data[i*64 +: 64], 64'h0123456789ABCDEF);
        @(negedge clk);
        b_wr_en = 2'b00;
        #1 chk("b_x3_stored", b_rd_data[127:64], 64'h0123456789ABCDEF);

        // mixed-port writes: port 0 and port 1 hit different registers
        for (int i = 1; i < 32; i += 2) begin
            @(negedge clk);
            a_wr_en = (i < 31) ? 2'b11 : 2'b01;
            a_wr_addr = {5'(i + 1), 5'(i)};
            a_wr_data = {32'(i + 1), 32'(i)};
            a_rd_addr = {5'(i + 1), 5'(i)};
        end
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            idle_a();
            a_rd_addr = {5'(32 - i), 5'(i)};
            #1 chk($sformatf("fill_x%0d", i), {32'd0, a_rd_data[31:0]}, 64'(i));
        end

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        count_low("midsweep_low_cycles");
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            a_rd_addr = {5'(i), 5'(i)};
            #1 chk($sformatf("cleared_x%0d", i), a_rd_data, 64'd0);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
